// File: rtl/ucc_pkg.sv
// ---------------------------------------------------------------------------
// ucc_pkg
// Shared definitions for the untrusted-code-compartment (UCC) tracker and
// the stack-protection stage that consumes its state.
//   ADDR_W        : program-counter width
//   RESET_HANDLER : address whose execution releases the RST state
//   ucc_state_e   : state encoding exported on ucc_state
// ---------------------------------------------------------------------------
package ucc_pkg;

  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_HANDLER = 16'h0000;

  // Encoding is visible on the ucc_state port, so the values are fixed
  // rather than left to the synthesis tool.
  typedef enum logic [1:0] {
    NOT_UCC = 2'b00,
    IN_UCC  = 2'b01,
    IRQ_ST  = 2'b10,
    RST_ST  = 2'b11
  } ucc_state_e;

endpackage

// File: rtl/ucc_state_fsm_if.sv
// ---------------------------------------------------------------------------
// ucc_state_fsm_if
// Bundles the core-side inputs and the tracker outputs.
//   pc           : current program counter (core -> tracker)
//   irq          : interrupt accepted this cycle (core -> tracker)
//   violation_in : registered violation from stack protection
//   ucc_state    : tracker state, ucc_state_e encoding
//   outside_ucc  : pc lies outside the UCC region (combinational)
//   reset        : MCU reset request, high while in RST
// The master modport is the driving side (core / bench), slave is the
// tracker itself.
// ---------------------------------------------------------------------------
interface ucc_state_fsm_if;
  import ucc_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              irq;
  logic              violation_in;
  logic [1:0]        ucc_state;
  logic              outside_ucc;
  logic              reset;

  modport master (
    output pc, irq, violation_in,
    input  ucc_state, outside_ucc, reset
  );

  modport slave (
    input  pc, irq, violation_in,
    output ucc_state, outside_ucc, reset
  );

endinterface

// File: rtl/ucc_region_cmp.sv
// ---------------------------------------------------------------------------
// ucc_region_cmp
// Combinational bounds comparator for the UCC region.
//   addr      : address under test
//   in_region : REGION_MIN <= addr <= REGION_MAX (unsigned, inclusive)
//   is_entry  : addr is the single legal entry point (REGION_MIN)
// ---------------------------------------------------------------------------
module ucc_region_cmp
  import ucc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] REGION_MIN = 16'hE000,
  parameter logic [ADDR_W-1:0] REGION_MAX = 16'hE0FF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_region,
  output logic              is_entry
);

  // The region has no wrap-around, so a plain pair of unsigned compares
  // is sufficient.
  assign in_region = (addr >= REGION_MIN) && (addr <= REGION_MAX);
  assign is_entry  = (addr == REGION_MIN);

endmodule

// File: rtl/ucc_state_fsm.sv
// ---------------------------------------------------------------------------
// ucc_state_fsm
// Tracks control flow into, within and out of the untrusted code
// compartment and enforces single-entry / single-exit, including the
// return address of any interrupt taken while inside the compartment.
// Ports:
//   clk            : the only clock
//   system_reset_n : asynchronous active-low reset
//   bus            : ucc_state_fsm_if slave (pc, irq, violation_in in;
//                    ucc_state, outside_ucc, reset out)
// ---------------------------------------------------------------------------
module ucc_state_fsm #(
  parameter logic [ucc_pkg::ADDR_W-1:0] UCC_MIN       = 16'hE000,
  parameter logic [ucc_pkg::ADDR_W-1:0] UCC_MAX       = 16'hE0FF,
  parameter logic [ucc_pkg::ADDR_W-1:0] UCC_EXIT      = 16'hE0FE,
  parameter logic [ucc_pkg::ADDR_W-1:0] RESET_HANDLER = ucc_pkg::RESET_HANDLER
) (
  input  logic           clk,
  input  logic           system_reset_n,
  ucc_state_fsm_if.slave bus
);
  import ucc_pkg::*;

  // A misplaced exit or a reset handler inside the region would make the
  // policy unenforceable, so such parameter sets are refused outright.
  if (!((UCC_MIN <= UCC_EXIT) && (UCC_EXIT <= UCC_MAX))) begin : g_bad_exit
    $fatal(1, "ucc_state_fsm: UCC_EXIT must lie within [UCC_MIN, UCC_MAX]");
  end
  if ((RESET_HANDLER >= UCC_MIN) && (RESET_HANDLER <= UCC_MAX)) begin : g_bad_rh
    $fatal(1, "ucc_state_fsm: RESET_HANDLER must lie outside the UCC region");
  end

  ucc_state_e        state;
  ucc_state_e        nxt_state;
  logic              reset_q;
  logic [ADDR_W-1:0] pc_prev;
  logic [ADDR_W-1:0] ret_pc;
  logic              in_region;
  logic              is_entry;

  ucc_region_cmp #(
    .REGION_MIN (UCC_MIN),
    .REGION_MAX (UCC_MAX)
  ) u_region (
    .addr      (bus.pc),
    .in_region (in_region),
    .is_entry  (is_entry)
  );

  // Transition rules. A violation wins over everything; within each state
  // the order of the checks encodes the remaining priorities (e.g. an irq
  // in inUCC beats the exit check of the same cycle).
  function automatic ucc_state_e next_state(
    input ucc_state_e        cur,
    input logic              viol,
    input logic              irq_now,
    input logic              in_reg,
    input logic              entry,
    input logic [ADDR_W-1:0] pc_now,
    input logic [ADDR_W-1:0] pc_last,
    input logic [ADDR_W-1:0] ret_addr
  );
    ucc_state_e res;
    res = RST_ST;
    if (viol) begin
      res = RST_ST;
    end else begin
      case (cur)
        NOT_UCC: begin
          if (!in_reg)
            res = NOT_UCC;
          else if (entry && !irq_now)
            res = IN_UCC;
          else
            res = RST_ST;
        end
        IN_UCC: begin
          if (irq_now)
            res = IRQ_ST;
          else if (in_reg)
            res = IN_UCC;
          else if (pc_last == UCC_EXIT)
            res = NOT_UCC;
          else
            res = RST_ST;
        end
        IRQ_ST: begin
          if (!in_reg)
            res = IRQ_ST;
          else if (pc_now == ret_addr)
            res = IN_UCC;
          else
            res = RST_ST;
        end
        RST_ST: begin
          res = (pc_now == RESET_HANDLER) ? NOT_UCC : RST_ST;
        end
        default: res = RST_ST;
      endcase
    end
    return res;
  endfunction

  assign nxt_state = next_state(state, bus.violation_in, bus.irq, in_region,
                                is_entry, bus.pc, pc_prev, ret_pc);

  // State register with registered reset output. ret_pc is only loaded on
  // the inUCC -> IRQ edge, so nested interrupts outside the region keep the
  // original return address.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state   <= RST_ST;
      reset_q <= 1'b1;
      pc_prev <= '0;
      ret_pc  <= '0;
    end else begin
      state   <= nxt_state;
      reset_q <= (nxt_state == RST_ST);
      pc_prev <= bus.pc;
      if ((state == IN_UCC) && (nxt_state == IRQ_ST))
        ret_pc <= bus.pc;
    end
  end

  assign bus.ucc_state   = state;
  assign bus.reset       = reset_q;
  assign bus.outside_ucc = !in_region;

endmodule

// File: tb/tb_ucc_state_fsm.sv
// ---------------------------------------------------------------------------
// tb_ucc_state_fsm
// Self-checking bench for ucc_state_fsm: directed scenarios followed by
// randomized pc/irq/violation traffic, all compared against a behavioural
// model of the compartment policy.
// ---------------------------------------------------------------------------
module tb_ucc_state_fsm;

  localparam logic [15:0] LO   = 16'hE000;
  localparam logic [15:0] HI   = 16'hE0FF;
  localparam logic [15:0] EXIT = 16'hE0FE;
  localparam logic [15:0] RH   = 16'h0000;

  // Model modes as plain integers matching the published port encoding.
  localparam int M_OUT = 0;
  localparam int M_IN  = 1;
  localparam int M_ISR = 2;
  localparam int M_RST = 3;

  logic clk;
  logic system_reset_n;

  ucc_state_fsm_if bus();

  ucc_state_fsm dut (
    .clk            (clk),
    .system_reset_n (system_reset_n),
    .bus            (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int          m_mode;
  logic [15:0] m_last_pc;
  logic [15:0] m_ret;

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against any hang in the stimulus sequence.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit inUcc(input logic [15:0] p);
    return (p >= LO) && (p <= HI);
  endfunction

  // Policy model: what should happen to the compartment given one cycle of
  // core activity.
  task automatic modelStep(input logic [15:0] p, input bit i, input bit v);
    int nxt;
    nxt = m_mode;
    if (v) nxt = M_RST;
    else if (m_mode == M_OUT) begin
      if (p == LO && !i)      nxt = M_IN;
      else if (inUcc(p))      nxt = M_RST;
    end else if (m_mode == M_IN) begin
      if (i) begin
        nxt   = M_ISR;
        m_ret = p;
      end else if (!inUcc(p)) begin
        nxt = (m_last_pc == EXIT) ? M_OUT : M_RST;
      end
    end else if (m_mode == M_ISR) begin
      if (inUcc(p)) nxt = (p == m_ret) ? M_IN : M_RST;
    end else begin
      if (p == RH) nxt = M_OUT;
    end
    m_mode    = nxt;
    m_last_pc = p;
  endtask

  // One cycle of stimulus: drive after the falling edge, check the
  // combinational flag, then check the registered outputs just after the
  // rising edge.
  task automatic applyStimulus(input logic [15:0] p, input bit i, input bit v);
    @(negedge clk);
    bus.pc           = p;
    bus.irq          = i;
    bus.violation_in = v;
    #1;
    checkOutput("outside_ucc", {31'd0, bus.outside_ucc}, {31'd0, !inUcc(p)});
    @(posedge clk);
    modelStep(p, i, v);
    #1;
    checkOutput("ucc_state", {30'd0, bus.ucc_state}, m_mode);
    checkOutput("reset", {31'd0, bus.reset}, {31'd0, (m_mode == M_RST)});
    checkOutput("ret_pc", {16'd0, dut.ret_pc}, {16'd0, m_ret});
  endtask

  task automatic goHome();
    applyStimulus(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] last_p;
    bit          i;
    bit          v;

    // Scenario 1: reset held, then released with pc at the reset handler.
    system_reset_n   = 1'b0;
    bus.pc           = 16'h0000;
    bus.irq          = 1'b0;
    bus.violation_in = 1'b0;
    m_mode           = M_RST;
    m_last_pc        = 16'h0000;
    m_ret            = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", {30'd0, bus.ucc_state}, 32'h3);
    checkOutput("rst_reset", {31'd0, bus.reset}, 32'h1);
    checkOutput("rst_ret_pc", {16'd0, dut.ret_pc}, 32'h0);
    @(negedge clk);
    system_reset_n = 1'b1;
    goHome();

    // Scenario 2: legal pass through the compartment.
    applyStimulus(16'h0100, 0, 0);
    for (int a = 16'hE000; a <= 16'hE0FE; a++) applyStimulus(a[15:0], 0, 0);
    applyStimulus(16'h0102, 0, 0);

    // Scenario 3: entry at a non-entry address, then exit from a
    // non-exit instruction.
    applyStimulus(16'h0100, 0, 0);
    applyStimulus(16'hE010, 0, 0);
    goHome();
    applyStimulus(16'hE000, 0, 0);
    for (int a = 16'hE001; a <= 16'hE005; a++) applyStimulus(a[15:0], 0, 0);
    applyStimulus(16'h0200, 0, 0);
    goHome();

    // Scenario 4: interrupt with correct and with forged return address.
    applyStimulus(16'hE000, 0, 0);
    applyStimulus(16'hE020, 1, 0);
    repeat (3) applyStimulus(16'hF000, 0, 0);
    applyStimulus(16'hF004, 1, 0);
    applyStimulus(16'hE020, 0, 0);
    applyStimulus(16'hE020, 1, 0);
    applyStimulus(16'hF000, 0, 0);
    applyStimulus(16'hE024, 0, 0);
    goHome();

    // Scenario 5: violation reported by stack protection while inside.
    applyStimulus(16'hE000, 0, 0);
    applyStimulus(16'hE030, 0, 0);
    applyStimulus(16'hE030, 0, 1);
    applyStimulus(16'h0000, 0, 1);
    goHome();

    // Entry coinciding with an interrupt is illegal.
    applyStimulus(16'hE000, 1, 0);
    goHome();

    // Scenario 6a: irq on the same edge as a legal exit.
    applyStimulus(16'hE000, 0, 0);
    applyStimulus(16'hE0FE, 0, 0);
    applyStimulus(16'h0300, 1, 0);
    checkOutput("irq_exit_ret", {16'd0, dut.ret_pc}, 32'h0300);

    // Scenario 6b: asynchronous reset in the middle of the ISR.
    applyStimulus(16'hF000, 0, 0);
    @(negedge clk);
    #2;
    system_reset_n = 1'b0;
    #1;
    checkOutput("async_state", {30'd0, bus.ucc_state}, 32'h3);
    checkOutput("async_reset", {31'd0, bus.reset}, 32'h1);
    checkOutput("async_ret_pc", {16'd0, dut.ret_pc}, 32'h0);
    m_mode    = M_RST;
    m_ret     = 16'h0000;
    m_last_pc = 16'h0000;
    @(negedge clk);
    system_reset_n = 1'b1;
    goHome();

    // Random traffic biased towards the interesting addresses.
    last_p = 16'h0000;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       p = 16'h0000;
        1:       p = LO;
        2:       p = EXIT;
        3:       p = HI;
        4:       p = LO - 16'd1;
        5:       p = HI + 16'd1;
        6:       p = LO + 16'($urandom_range(0, 255));
        7:       p = m_ret;
        8:       p = last_p;
        default: p = 16'($urandom_range(0, 65535));
      endcase
      i = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 19) == 0);
      applyStimulus(p, i, v);
      last_p = p;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
